uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver with an output FIFO. It replaces the fixed 9-bit receiver behind `top`. Data width, parity, stop bits, bit period and buffer depth are all configurable. It deserialises the asynchronous `uart_rxd_out` line into words. Each word is tagged with its framing and parity status, and words are delivered to the fabric through a valid/ready FIFO with overrun and break detection.

## Interface
- `CLKS_PER_BIT`, 17, clock cycles per bit period; must be ≥ 8. 17 gives about 170 ns per bit at 100 MHz.
- `DATA_BITS`, 9, data bits per frame (5..9), received LSB first.
- `PARITY`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, stop bits per frame (1 or 2).
- `FIFO_DEPTH`, 4, output FIFO entries; must be a power of 2, ≥ 2.
- `CLK100MHZ` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `uart_rxd_out` in 1: serial line, asynchronous, idles high.
- `rxData` out DATA_BITS: word at the FIFO head.
- `rx_frame_err` out 1: the FIFO-head word had stop bit 0.
- `rx_parity_err` out 1: the FIFO-head word had a parity mismatch. Always 0 when PARITY = 0.
- `rx_valid` out 1: the FIFO is non-empty.
- `rx_ready` in 1: consumer accepts the head word on a cycle where `rx_valid && rx_ready`.
- `rx_overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `rx_break` out 1: sticky; a break condition was detected.
- `clr_err` in 1: a one-cycle pulse that clears `rx_overrun` and `rx_break`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Input synchroniser:** `uart_rxd_out` passes through a 2-flop synchroniser. Both flops reset to 1. All frame logic uses the synchronised signal `rxs`.
- **Frame FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. A bit counter and a bit-index counter are reset on every state entry.
- **IDLE:**
  - `rxs` == 0 → START, bit counter = 0.
- **START:**
  - Waits until the bit counter reaches (CLKS_PER_BIT-1)/2, the mid-start point.
  - If `rxs` is 1 there → IDLE. This is a false start: nothing is pushed and no flag is set.
  - Otherwise → DATA.
- **DATA:**
  - Every CLKS_PER_BIT cycles after mid-start, samples `rxs` into the shift register at index 0..DATA_BITS-1, LSB first.
  - After the last data bit → PARITY if PARITY ≠ 0, else → STOP.
- **PARITY:**
  - Samples one bit.
  - parity_err = (XOR of data ^ sampled bit) ≠ 0 for even parity; == 0 for odd parity.
- **STOP:**
  - Samples each stop bit at mid-bit. frame_err = any sampled stop bit was 0.
  - At the final stop sample the word {data, frame_err, parity_err} is pushed, in that same cycle.
  - Next state is IDLE, so a start edge arriving in the second half of the stop bit is caught. Back-to-back frames must not be lost.
  - Break case: data == 0, the stop bit was 0 and parity (if enabled) was 0 → the frame is still pushed, `rx_break` is set, and next state is BREAK_WAIT.
- **BREAK_WAIT:** waits for `rxs` == 1, then → IDLE.
- **FIFO:**
  - First-word-fall-through: `rxData`, `rx_frame_err` and `rx_parity_err` show the head entry whenever `rx_valid` is 1. Their contents are don't-care when `rx_valid` is 0.
  - Pop when `rx_valid && rx_ready`.
  - Push while not full → accepted.
  - Push while full with a pop in the same cycle → accepted, count unchanged.
  - Push while full with no pop → frame discarded, `rx_overrun` set. The FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is a separate register.
- **Sticky flags:**
  - `clr_err` clears both sticky flags.
  - If a set event and `clr_err` occur in the same cycle, set wins.
- **Reset values:**
  - State IDLE; pointers, count and counters 0.
  - `rx_valid` 0, `rx_overrun` 0, `rx_break` 0, `fifo_count` 0.
  - `rxData` 0, `rx_frame_err` 0, `rx_parity_err` 0.
- **Reset mid-frame:** the partial frame is discarded and the FIFO is emptied. After reset is released, the receiver resynchronises on the next falling edge seen in IDLE, including one that occurs mid-frame on a still-active line.

## Timing
- From the `uart_rxd_out` falling edge to entry into START: 2–3 cycles (synchroniser).
- Data bit k is sampled (CLKS_PER_BIT-1)/2 + (k+1)·CLKS_PER_BIT cycles after START entry.
- Push occurs on the final stop-sample cycle.
  - `rx_valid` and `fifo_count` update on the next rising edge, i.e. 1 cycle of push latency.
- Pop: `fifo_count` decrements and the next head appears on the edge after the `rx_valid && rx_ready` cycle.
- Throughput: one frame per (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT cycles, sustained indefinitely while `rx_ready` = 1.
- Tolerated baud mismatch: ≥ ±3 % with defaults.
  - Example: a 166.67 ns bit time with CLKS_PER_BIT = 17 is about 2 % off and must decode correctly.

## Test plan
Defaults unless stated; the bit time is 166.67 ns.

- **Basic reception:** release reset, send 0x101 with stop 1, `rx_ready` = 1 → one `rx_valid` beat with `rxData` = 0x101, `rx_frame_err` = 0, `rx_parity_err` = 0.
- **Back-to-back with framing error:** send 0x101, 0x102, 0x103 (stop 1) then 0x104 (stop 0), with no idle gap and `rx_ready` = 0 → `fifo_count` reaches 4. Reading returns 0x101, 0x102, 0x103, 0x104 in order; only 0x104 has `rx_frame_err` = 1. `rx_break` stays 0.
- **Overrun:** with `rx_ready` held 0, send 5 frames → `fifo_count` = 4 and `rx_overrun` = 1. The first four words are intact and the 5th is dropped. A `clr_err` pulse clears `rx_overrun`.
- **Parity and data width:** PARITY = 1, DATA_BITS = 8.
  - Send 0xA5 with parity bit 0 → `rx_parity_err` = 0.
  - Send 0xA5 with parity bit 1 → `rx_parity_err` = 1.
- **False start and break:**
  - A 5-cycle low glitch → no push, FSM back in IDLE.
  - Line held low for 3 frame times → one word 0x000 with `rx_frame_err` = 1 and `rx_break` = 1. No further pushes until the line returns high, then the next frame decodes normally.
- **Reset mid-frame:** assert `reset` (low) during data bit 4, for 100 ns → all outputs return to their reset values immediately, asynchronously. A complete frame sent after release decodes correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with status tagging and FWFT output FIFO
//
// Deserialises uart_rxd_out (LSB first, optional parity, 1-2 stop bits) into
// words tagged with frame/parity error bits, buffered in a valid/ready FIFO.
// Ports:
//   CLK100MHZ     - clock, rising edge
//   reset         - asynchronous active-low reset
//   uart_rxd_out  - serial input, idles high
//   rxData        - data word at FIFO head (0 when empty)
//   rx_frame_err  - head word had a 0 stop bit
//   rx_parity_err - head word had a parity mismatch
//   rx_valid      - FIFO non-empty
//   rx_ready      - consumer pops head when rx_valid && rx_ready
//   rx_overrun    - sticky: frame dropped because FIFO full
//   rx_break      - sticky: break condition seen
//   clr_err       - pulse clearing rx_overrun and rx_break
//   fifo_count    - FIFO occupancy
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 17,
  parameter int DATA_BITS    = 9,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          uart_rxd_out,
  output logic [DATA_BITS-1:0]          rxData,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic                          rx_break,
  input  logic                          clr_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
  } state_t;

  logic                 r_sync1, r_rxs;
  state_t               r_state;
  logic [CW-1:0]        r_bit_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [PW:0]          r_count;

  logic w_tick, w_push, w_frame_err, w_par_xor, w_parity_err, w_break;
  logic w_pop, w_full, w_wr, w_ovr;
  logic [EW-1:0] w_head;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd_out;
      r_rxs   <= r_sync1;
    end
  end

  // After mid-start, every full bit period lands on the middle of a bit.
  assign w_tick       = (r_bit_cnt == LAST);
  assign w_push       = (r_state == S_STOP) && w_tick && (r_idx == IW'(STOP_BITS - 1));
  assign w_frame_err  = r_stop_err | ~r_rxs;
  assign w_par_xor    = (^r_shift) ^ r_par_bit;
  assign w_parity_err = (PARITY == 1) ? w_par_xor : (PARITY == 2) ? ~w_par_xor : 1'b0;
  // Break: an all-zero frame including stop (and parity bit when present).
  assign w_break      = w_push && (r_shift == '0) && w_frame_err &&
                        ((PARITY == 0) || !r_par_bit);

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      if (w_break)      rx_break <= 1'b1;
      else if (clr_err) rx_break <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state   <= S_START;
            r_bit_cnt <= '0;
            r_idx     <= '0;
          end
        end
        S_START: begin
          if (r_bit_cnt == MID) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_state   <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_idx == IW'(DATA_BITS - 1)) begin
              r_idx      <= '0;
              r_stop_err <= 1'b0;
              r_state    <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_bit_cnt  <= '0;
            r_idx      <= '0;
            r_par_bit  <= r_rxs;
            r_stop_err <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_bit_cnt  <= '0;
            r_stop_err <= w_frame_err;
            if (w_push) begin
              // Return to IDLE straight from mid-stop so a back-to-back start edge is caught.
              r_idx   <= '0;
              r_state <= w_break ? S_BREAK_WAIT : S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          if (r_rxs) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_idx     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: a push when full is still accepted if the head pops the same cycle.
  assign w_pop  = rx_valid && rx_ready;
  assign w_full = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovr  = w_push && w_full && !w_pop;

  always_ff @(posedge CLK100MHZ) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_shift, w_frame_err, w_parity_err};
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_ovr)        rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
    end
  end

  // Head fields are forced to 0 while empty so reset values hold without resetting storage.
  assign w_head        = r_mem[r_rd_ptr];
  assign rx_valid      = (r_count != '0);
  assign fifo_count    = r_count;
  assign rxData        = rx_valid ? w_head[EW-1:2] : '0;
  assign rx_frame_err  = rx_valid ? w_head[1] : 1'b0;
  assign rx_parity_err = rx_valid ? w_head[0] : 1'b0;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam real BIT_NS = 166.67;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_a = 1'b1, line_b = 1'b1;
  logic ready_a = 1'b0, ready_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;

  logic [8:0] data_a;
  logic       fe_a, pe_a, valid_a, ovr_a, brk_a;
  logic [2:0] cnt_a;
  logic [7:0] data_b;
  logic       fe_b, pe_b, valid_b, ovr_b, brk_b;
  logic [2:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] q_a[$];
  logic [9:0]  q_b[$];

  uart_rx_param dut_a (
    .CLK100MHZ(clk), .reset(rst_n), .uart_rxd_out(line_a),
    .rxData(data_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .rx_overrun(ovr_a),
    .rx_break(brk_a), .clr_err(clr_a), .fifo_count(cnt_a)
  );

  uart_rx_param #(.DATA_BITS(8), .PARITY(1)) dut_b (
    .CLK100MHZ(clk), .reset(rst_n), .uart_rxd_out(line_b),
    .rxData(data_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .rx_overrun(ovr_b),
    .rx_break(brk_b), .clr_err(clr_b), .fifo_count(cnt_b)
  );

  always #5 clk = ~clk;

  // Record every accepted beat; inputs only change #1 after a rising edge.
  always @(negedge clk) begin
    if (valid_a && ready_a) q_a.push_back({fe_a, pe_a, data_a});
    if (valid_b && ready_b) q_b.push_back({fe_b, pe_b, data_b});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [8:0] d, input logic stop);
    line_a = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 9; i++) begin
      line_a = d[i];
      #(BIT_NS);
    end
    line_a = stop;
    #(BIT_NS);
    line_a = 1'b1;
  endtask

  task automatic send_b(input logic [7:0] d, input logic p);
    line_b = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      line_b = d[i];
      #(BIT_NS);
    end
    line_b = p;
    #(BIT_NS);
    line_b = 1'b1;
    #(BIT_NS);
  endtask

  task automatic set_ready_a(input logic v);
    @(posedge clk);
    #1 ready_a = v;
  endtask

  task automatic drain_a(input int n);
    set_ready_a(1'b1);
    repeat (n) @(posedge clk);
    #1 ready_a = 1'b0;
  endtask

  task automatic pulse_clr_a();
    @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] pop_a();
    if (q_a.size() > 0) return q_a.pop_front();
    return 11'h7ff;
  endfunction

  function automatic logic [9:0] pop_b();
    if (q_b.size() > 0) return q_b.pop_front();
    return 10'h3ff;
  endfunction

  initial begin
    logic [10:0] ea;
    logic [9:0]  eb;
    logic [8:0]  d;

    // Reset state
    wait_cyc(3);
    check("rst_valid", valid_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_break", brk_a, 0);
    check("rst_data", data_a, 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // Basic reception
    set_ready_a(1'b1);
    send_a(9'h101, 1'b1);
    wait_cyc(10);
    check("basic_beats", q_a.size(), 1);
    ea = pop_a();
    check("basic_data", ea[8:0], 9'h101);
    check("basic_fe", ea[10], 0);
    check("basic_pe", ea[9], 0);
    check("basic_count", cnt_a, 0);

    // Back-to-back with framing error on the last frame
    set_ready_a(1'b0);
    send_a(9'h101, 1'b1);
    send_a(9'h102, 1'b1);
    send_a(9'h103, 1'b1);
    send_a(9'h104, 1'b0);
    wait_cyc(5);
    check("b2b_count", cnt_a, 4);
    check("b2b_break", brk_a, 0);
    drain_a(8);
    wait_cyc(2);
    check("b2b_beats", q_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ea = pop_a();
      check("b2b_data", ea[8:0], 9'h101 + 9'(i));
      check("b2b_fe", ea[10], (i == 3) ? 1 : 0);
    end
    check("b2b_empty", cnt_a, 0);

    // Overrun: fifth frame dropped
    for (int i = 0; i < 5; i++) send_a(9'h011 + 9'(i), 1'b1);
    wait_cyc(5);
    check("ovr_count", cnt_a, 4);
    check("ovr_flag", ovr_a, 1);
    pulse_clr_a();
    wait_cyc(1);
    check("ovr_clr", ovr_a, 0);
    drain_a(8);
    wait_cyc(2);
    check("ovr_beats", q_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ea = pop_a();
      check("ovr_data", ea[8:0], 9'h011 + 9'(i));
    end
    check("ovr_empty", cnt_a, 0);

    // Even parity, 8 data bits: 0xA5 has four ones
    @(posedge clk);
    #1 ready_b = 1'b1;
    send_b(8'hA5, 1'b0);
    send_b(8'hA5, 1'b1);
    wait_cyc(5);
    check("par_beats", q_b.size(), 2);
    eb = pop_b();
    check("par_ok_data", eb[7:0], 8'hA5);
    check("par_ok_pe", eb[8], 0);
    eb = pop_b();
    check("par_bad_pe", eb[8], 1);
    check("par_bad_fe", eb[9], 0);

    // False start glitch, then a normal frame
    set_ready_a(1'b1);
    line_a = 1'b0;
    #50;
    line_a = 1'b1;
    wait_cyc(40);
    check("glitch_beats", q_a.size(), 0);
    check("glitch_count", cnt_a, 0);
    send_a(9'h0AA, 1'b1);
    wait_cyc(10);
    ea = pop_a();
    check("glitch_next", ea[8:0], 9'h0AA);

    // Break: line low for three frame times
    line_a = 1'b0;
    #(33.0 * BIT_NS);
    check("brk_beats", q_a.size(), 1);
    ea = pop_a();
    check("brk_data", ea[8:0], 0);
    check("brk_fe", ea[10], 1);
    check("brk_flag", brk_a, 1);
    line_a = 1'b1;
    wait_cyc(20);
    check("brk_nomore", q_a.size(), 0);
    send_a(9'h1C3, 1'b1);
    wait_cyc(10);
    ea = pop_a();
    check("brk_next_data", ea[8:0], 9'h1C3);
    check("brk_next_fe", ea[10], 0);
    pulse_clr_a();
    wait_cyc(1);
    check("brk_clr", brk_a, 0);

    // Reset during data bit 4 with a word already buffered
    set_ready_a(1'b0);
    send_a(9'h055, 1'b1);
    wait_cyc(5);
    check("rstmid_pre", cnt_a, 1);
    d = 9'h1FF;
    line_a = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      line_a = d[i];
      #(BIT_NS);
    end
    line_a = d[4];
    #(BIT_NS / 2.0);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", valid_a, 0);
    check("rstmid_count", cnt_a, 0);
    check("rstmid_data", data_a, 0);
    check("rstmid_fe", fe_a, 0);
    #99;
    rst_n = 1'b1;
    line_a = 1'b1;
    wait_cyc(30);
    q_a.delete();
    set_ready_a(1'b1);
    send_a(9'h0F0, 1'b1);
    wait_cyc(10);
    check("rstmid_beats", q_a.size(), 1);
    ea = pop_a();
    check("rstmid_after", ea[8:0], 9'h0F0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
